// File: rtl/modular_subtractor_kyber_pipe.sv
// Two-stage streaming (inp1 - inp2) mod Q for Kyber with valid/ready on both sides.
// Optional KYBER_SUB_RANGE_CHK_EN adds range_err, flagging operands >= Q alongside their result.
`timescale 1ns/1ps
module modular_subtractor_kyber_pipe #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned Q     = 3329
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] inp1,
  input  logic [WIDTH-1:0] inp2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out
`ifdef KYBER_SUB_RANGE_CHK_EN
  ,
  output logic             range_err
`endif
);

  localparam logic signed [WIDTH+1:0] Q_S   = (WIDTH+2)'(Q);
  localparam logic signed [WIDTH+1:0] NEG_Q = -Q_S;
  localparam logic signed [WIDTH+1:0] Q2_S  = (WIDTH+2)'(2 * Q);
  localparam logic [WIDTH-1:0]        Q_U   = WIDTH'(Q);

  logic                    s1_valid;
  logic signed [WIDTH:0]   s1_diff;
  logic                    s1_load;
  logic                    s2_load;
  logic signed [WIDTH+1:0] diff_ext;
  logic signed [WIDTH+1:0] fixed;

  assign s2_load  = !out_valid || out_ready;
  assign s1_load  = !s1_valid || s2_load;
  assign in_ready = s1_load;

  // One extra sign bit keeps d + 2Q representable for the most negative difference.
  always_comb begin
    diff_ext = {s1_diff[WIDTH], s1_diff};
    fixed    = diff_ext;
    if (diff_ext < NEG_Q)
      fixed = diff_ext + Q2_S;
    else if (diff_ext[WIDTH+1])
      fixed = diff_ext + Q_S;
    else if (diff_ext >= Q_S)
      fixed = diff_ext - Q_S;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_diff  <= '0;
    end else if (s1_load) begin
      s1_valid <= in_valid;
      if (in_valid)
        s1_diff <= $signed({1'b0, inp1} - {1'b0, inp2});
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out       <= '0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid)
        out <= WIDTH'(fixed);
    end
  end

`ifdef KYBER_SUB_RANGE_CHK_EN
  logic s1_flag;
  logic s2_flag;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_flag <= 1'b0;
      s2_flag <= 1'b0;
    end else begin
      if (s1_load && in_valid)
        s1_flag <= (inp1 >= Q_U) || (inp2 >= Q_U);
      if (s2_load && s1_valid)
        s2_flag <= s1_flag;
    end
  end

  assign range_err = out_valid && s2_flag;
`endif

endmodule
